// File: rtl/adder_result_capture_pkg.sv
// Shared types for the multicycle adder capture block: operand/sum widths and FSM states.
package adder_pkg;

  localparam int ADD_W = 381;

  typedef logic [ADD_W-1:0] operand_t;
  typedef logic [ADD_W:0]   sum_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/adder_result_capture_if.sv
// Operand-in / result-out valid-ready bundle between a client and adder_result_capture.
interface adder_result_capture_if #(
  parameter int WIDTH = adder_pkg::ADD_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/adder_result_capture_edge_rise_det.sv
// Registered rising-edge detector for a strobe already in the clk domain.
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clk) begin
    if (!reset) din_d <= 1'b0;
    else        din_d <= din;
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/adder_result_capture.sv
// Drives stable operands into an external multicycle adder, launches on one add_clk
// rise, captures the sum on the next, and returns it over a valid/ready handshake.
module adder_result_capture
  import adder_pkg::*;
#(
  parameter int WIDTH    = ADD_W,
  parameter int MAX_WAIT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   add_clk,
  adder_result_capture_if.slave  bus,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  input  logic [WIDTH:0]         sum_in,
  output logic                   timeout
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic               rise;
  logic               cnt_last;
  logic               cnt_clr;
  logic               latch;
  logic               capture;
  logic               abort;
  logic [WIDTH:0]     result_q;

  edge_rise_det u_add_clk_rise (
    .clk   (clk),
    .reset (reset),
    .din   (add_clk),
    .rise  (rise)
  );

  assign cnt_last = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  // A rise outranks an expiring wait counter on the same cycle.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = ARM;
          latch      = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      ARM: begin
        if (rise) begin
          state_next = SETTLE;
          cnt_clr    = 1'b1;
        end else if (cnt_last) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      SETTLE: begin
        if (rise) begin
          state_next = HOLD;
          capture    = 1'b1;
        end else if (cnt_last) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      timeout  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (cnt_clr)                               wait_cnt <= '0;
      else if (state == ARM || state == SETTLE)  wait_cnt <= wait_cnt + 1'b1;
      if (abort) timeout <= 1'b1;
      if (latch) begin
        op_a <= bus.in_a;
        op_b <= bus.in_b;
      end
      if (capture) result_q <= sum_in;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.result    = result_q;

endmodule
